// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone eligible port wins; on a tie the port
// that was not granted last wins.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic a_elig_i,
    input  logic b_elig_i,
    input  logic last_i,
    output logic vld_o,
    output logic gnt_o
);

    // Pure combinational decision, no state held here.
    always_comb begin
        vld_o = a_elig_i | b_elig_i;
        gnt_o = PORT_A;
        if (a_elig_i && b_elig_i)
            gnt_o = (last_i == PORT_A) ? PORT_B : PORT_A;
        else if (b_elig_i)
            gnt_o = PORT_B;
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one synchronous single-port memory between two requesters.
// Each access walks IDLE -> ACCESS -> CAPTURE -> IDLE; the winner is acked
// in the first IDLE cycle, which is also when the other port can be granted.
module memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              a_req,
    input  logic              a_wr,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_wr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wr,
    output logic              mem_cs,
    input  logic [DATA_W-1:0] mem_o,
    output logic              busy
);

    state_e              state_q, state_d;
    logic                last_q, gnt_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_data_q;
    logic                mem_wr_q, mem_cs_q;
    logic                a_ack_q, b_ack_q;
    logic [DATA_W-1:0]   a_rdata_q, b_rdata_q;

    logic                a_elig, b_elig, grant_vld, grant;
    logic                win_wr;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;

    // A port that is being acked this cycle has already been served.
    assign a_elig = (state_q == IDLE) && a_req && !a_ack_q;
    assign b_elig = (state_q == IDLE) && b_req && !b_ack_q;

    rr_arbiter2 u_rr (
        .a_elig_i (a_elig),
        .b_elig_i (b_elig),
        .last_i   (last_q),
        .vld_o    (grant_vld),
        .gnt_o    (grant)
    );

    // Select the winning requester's command fields.
    always_comb begin
        win_wr   = a_wr;
        win_addr = a_addr;
        win_data = a_wdata;
        if (grant == PORT_B) begin
            win_wr   = b_wr;
            win_addr = b_addr;
            win_data = b_wdata;
        end
    end

    // Next-state logic; ACCESS and CAPTURE are single fixed cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = ACCESS;
            ACCESS:  state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Memory command, grant bookkeeping, acks and read-data capture.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            last_q     <= PORT_B;
            gnt_q      <= PORT_A;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_wr_q   <= 1'b0;
            mem_cs_q   <= 1'b1;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            a_ack_q  <= 1'b0;
            b_ack_q  <= 1'b0;
            mem_cs_q <= 1'b1;
            case (state_q)
                IDLE: if (grant_vld) begin
                    gnt_q      <= grant;
                    last_q     <= grant;
                    mem_wr_q   <= win_wr;
                    mem_addr_q <= win_addr;
                    mem_data_q <= win_data;
                    mem_cs_q   <= 1'b0;
                end
                CAPTURE: begin
                    if (gnt_q == PORT_A) begin
                        a_ack_q <= 1'b1;
                        if (!mem_wr_q) a_rdata_q <= mem_o;
                    end else begin
                        b_ack_q <= 1'b1;
                        if (!mem_wr_q) b_rdata_q <= mem_o;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_address = mem_addr_q;
    assign mem_data    = mem_data_q;
    assign mem_wr      = mem_wr_q;
    assign mem_cs      = mem_cs_q;
    assign a_ack       = a_ack_q;
    assign b_ack       = b_ack_q;
    assign a_rdata     = a_rdata_q;
    assign b_rdata     = b_rdata_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a synchronous memory model attached.
module tb_memory_arbiter;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       a_req, a_wr, b_req, b_wr;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_ack, b_ack, mem_wr, mem_cs, busy;
    logic [7:0] a_rdata, b_rdata, mem_address, mem_data, mem_o;

    logic [7:0] mem [0:255];
    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    memory_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .Clock(Clock), .Reset(Reset),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wr(mem_wr),
        .mem_cs(mem_cs), .mem_o(mem_o), .busy(busy)
    );

    // Memory: select on the clock edge while cs is low; reads are registered.
    always @(posedge Clock) begin
        if (!mem_cs) begin
            if (mem_wr) mem[mem_address] <= mem_data;
            else        mem_o <= mem[mem_address];
        end
    end

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        a_req = 0; b_req = 0;
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    // One access by a single port; expects ack exactly 3 cycles later.
    task automatic access(input logic port, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp_rd, input string name);
        int n = 0;
        logic got = 0, other = 0;
        logic [7:0] rd;
        if (port == 1'b0) begin a_req = 1; a_wr = wr; a_addr = addr; a_wdata = wdata; end
        else              begin b_req = 1; b_wr = wr; b_addr = addr; b_wdata = wdata; end
        while (!got && n < 8) begin
            @(negedge Clock);
            n++;
            if (n == 1) begin
                checks++;
                if (mem_cs !== 1'b0 || mem_address !== addr || mem_wr !== wr ||
                    (wr && mem_data !== wdata)) begin
                    errors++;
                    $display("FAIL %s access cmd: cs=%b addr=%h wr=%b data=%h, need cs=0 addr=%h wr=%b data=%h",
                             name, mem_cs, mem_address, mem_wr, mem_data, addr, wr, wdata);
                end
            end
            if (n == 2) begin
                checks++;
                if (mem_cs !== 1'b1 || busy !== 1'b1 || mem_address !== addr || mem_wr !== wr) begin
                    errors++;
                    $display("FAIL %s capture hold: cs=%b busy=%b addr=%h wr=%b, need cs=1 busy=1 addr=%h wr=%b",
                             name, mem_cs, busy, mem_address, mem_wr, addr, wr);
                end
            end
            if ((port ? a_ack : b_ack) === 1'b1) other = 1;
            if ((port ? b_ack : a_ack) === 1'b1) got = 1;
        end
        checks++;
        if (!got || n != 3) begin
            errors++;
            $display("FAIL %s latency: got=%b after %0d cycles, need ack after 3", name, got, n);
        end
        checks++;
        if (other) begin
            errors++;
            $display("FAIL %s other ack: other port pulsed ack, need none", name);
        end
        rd = port ? b_rdata : a_rdata;
        checks++;
        if (rd !== exp_rd) begin
            errors++;
            $display("FAIL %s rdata: got %h need %h", name, rd, exp_rd);
        end
        if (port == 1'b0) a_req = 0; else b_req = 0;
        @(negedge Clock);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        a_req = 0; a_wr = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_wr = 0; b_addr = 0; b_wdata = 0;
        repeat (2) @(negedge Clock);
        checks++;
        if (busy !== 0 || mem_cs !== 1 || mem_wr !== 0 || mem_address !== 0 || mem_data !== 0 ||
            a_ack !== 0 || b_ack !== 0 || a_rdata !== 0 || b_rdata !== 0) begin
            errors++;
            $display("FAIL reset values: busy=%b cs=%b wr=%b addr=%h data=%h acks=%b%b rd=%h/%h",
                     busy, mem_cs, mem_wr, mem_address, mem_data, a_ack, b_ack, a_rdata, b_rdata);
        end
        Reset = 1'b0;
    endtask

    task automatic test_a_write_read();
        do_reset();
        access(1'b0, 1'b1, 8'h03, 8'h4C, 8'h00, "a_write");
        access(1'b0, 1'b0, 8'h03, 8'h00, 8'h4C, "a_read");
    endtask

    task automatic test_tie_first();
        int ta = 0, tb = 0;
        logic a_first = 0;
        do_reset();
        a_req = 1; a_wr = 1; a_addr = 8'h04; a_wdata = 8'hB3;
        b_req = 1; b_wr = 0; b_addr = 8'h04; b_wdata = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            @(negedge Clock);
            if (k == 1) a_first = (mem_address === 8'h04 && mem_wr === 1'b1 && mem_cs === 1'b0);
            if (a_ack === 1'b1) begin ta = k; a_req = 0; end
            if (b_ack === 1'b1) begin tb = k; b_req = 0; end
        end
        checks++;
        if (!a_first) begin
            errors++;
            $display("FAIL tie first grant: wr=%b addr=%h, need A write to 04", mem_wr, mem_address);
        end
        checks++;
        if (ta != 3 || tb != 6) begin
            errors++;
            $display("FAIL tie ack timing: a at %0d b at %0d, need 3 and 6", ta, tb);
        end
        checks++;
        if (b_rdata !== 8'hB3 || a_rdata !== 8'h00) begin
            errors++;
            $display("FAIL tie rdata: a=%h b=%h, need a=00 b=B3", a_rdata, b_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int cs_low = 0;
        logic [7:0] seq [4];
        logic [3:0] a_at = 0, b_at = 0;
        do_reset();
        a_req = 1; a_wr = 0; a_addr = 8'h03;
        b_req = 1; b_wr = 0; b_addr = 8'h04;
        for (int k = 1; k <= 12; k++) begin
            @(negedge Clock);
            if (mem_cs === 1'b0) begin
                if (cs_low < 4) seq[cs_low] = mem_address;
                cs_low++;
            end
            if (a_ack === 1'b1) a_at = (k == 3 || k == 9) ? a_at + 1 : 4'hF;
            if (b_ack === 1'b1) b_at = (k == 6 || k == 12) ? b_at + 1 : 4'hF;
        end
        a_req = 0; b_req = 0;
        checks++;
        if (cs_low != 4) begin
            errors++;
            $display("FAIL b2b cs count: %0d low cycles in 12, need 4", cs_low);
        end
        checks++;
        if (seq[0] !== 8'h03 || seq[1] !== 8'h04 || seq[2] !== 8'h03 || seq[3] !== 8'h04) begin
            errors++;
            $display("FAIL b2b grant order: %h %h %h %h, need 03 04 03 04", seq[0], seq[1], seq[2], seq[3]);
        end
        checks++;
        if (a_at != 2 || b_at != 2) begin
            errors++;
            $display("FAIL b2b ack pattern: a=%0d b=%0d, need 2 and 2 at cycles 3,9 / 6,12", a_at, b_at);
        end
        checks++;
        if (a_rdata !== 8'h4C || b_rdata !== 8'hB3) begin
            errors++;
            $display("FAIL b2b rdata: a=%h b=%h, need 4C B3", a_rdata, b_rdata);
        end
        @(negedge Clock);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b drain: busy=%b need 0", busy);
        end
    endtask

    task automatic test_b_write_drop();
        do_reset();
        access(1'b1, 1'b0, 8'h04, 8'h00, 8'hB3, "b_read");
        access(1'b1, 1'b1, 8'h10, 8'h55, 8'hB3, "b_write");
        checks++;
        if (busy !== 1'b0 || mem_cs !== 1'b1) begin
            errors++;
            $display("FAIL b_write regrant: busy=%b cs=%b, need 0 1", busy, mem_cs);
        end
        access(1'b1, 1'b0, 8'h10, 8'h00, 8'h55, "b_readback");
    endtask

    task automatic test_reset_abort();
        do_reset();
        access(1'b0, 1'b0, 8'h03, 8'h00, 8'h4C, "pre_abort");
        a_req = 1; a_wr = 0; a_addr = 8'h03;
        @(negedge Clock);
        checks++;
        if (mem_cs !== 1'b0) begin
            errors++;
            $display("FAIL abort setup: cs=%b need 0", mem_cs);
        end
        Reset = 1'b1;
        #1;
        checks++;
        if (mem_cs !== 1 || busy !== 0 || a_ack !== 0 || b_ack !== 0 || a_rdata !== 8'h00) begin
            errors++;
            $display("FAIL abort reset: cs=%b busy=%b acks=%b%b a_rdata=%h, need 1 0 00 00",
                     mem_cs, busy, a_ack, b_ack, a_rdata);
        end
        a_req = 0;
        @(negedge Clock);
        Reset = 1'b0;
        access(1'b0, 1'b0, 8'h04, 8'h00, 8'hB3, "post_abort");
    endtask

    task automatic test_idle();
        int bad = 0;
        a_req = 0; b_req = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clock);
            if (busy !== 0 || mem_cs !== 1 || a_ack !== 0 || b_ack !== 0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle quiet: %0d of 20 cycles not idle, need 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_a_write_read();
        test_tie_first();
        test_back_to_back();
        test_b_write_drop();
        test_reset_abort();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named Clock and Reset.
REQ-002 Parameter ADDR_W, default 8, SHALL set the address width of all address ports.
REQ-003 Parameter DATA_W, default 8, SHALL set the data width of all data ports.
REQ-004 The ports SHALL be, one per line: name  direction  width  meaning.
- Clock  in  1  rising-edge clock
- Reset  in  1  async active-high reset
- a_req  in  1  port A access request, level
- a_wr  in  1  port A 1=write 0=read
- a_addr  in  ADDR_W  port A address
- a_wdata  in  DATA_W  port A write data
- a_ack  out  1  port A completion pulse
- a_rdata  out  DATA_W  port A read data
- b_req / b_wr / b_addr / b_wdata / b_ack / b_rdata  same as port A, for port B
- mem_address  out  ADDR_W  to Memory address
- mem_data  out  DATA_W  to Memory data
- mem_wr  out  1  to Memory wr, 1=write
- mem_cs  out  1  to Memory cs, active-low select
- mem_o  in  DATA_W  from Memory output o
- busy  out  1  high whenever state is not IDLE

Function
REQ-005 The FSM SHALL have three states, IDLE, ACCESS and CAPTURE, with transitions IDLE->ACCESS when an eligible request exists, ACCESS->CAPTURE unconditionally, and CAPTURE->IDLE unconditionally.
REQ-006 A port SHALL be eligible in IDLE when its req is 1 and its ack is 0 in that cycle.
REQ-007 When exactly one port is eligible, that port SHALL be granted; when both are eligible, the port not granted last SHALL be granted (round robin).
REQ-008 On the IDLE->ACCESS edge, the winner's wr, addr and wdata SHALL be latched into mem_wr, mem_address and mem_data, and mem_cs SHALL be driven to 0.
REQ-009 mem_cs SHALL be 0 for exactly the ACCESS cycle and 1 in all other cycles.
REQ-010 mem_address, mem_data and mem_wr SHALL stay stable from ACCESS through CAPTURE.
REQ-011 On the CAPTURE->IDLE edge of a read, mem_o SHALL be loaded into the granted port's rdata.
REQ-012 On a write, the granted port's rdata SHALL be left unchanged.
REQ-013 The non-granted port's rdata SHALL never change.
REQ-014 The granted port's ack SHALL be a registered one-cycle pulse in the first IDLE cycle after CAPTURE.
REQ-015 Latency SHALL be fixed: a request sampled in IDLE cycle T completes with ack in cycle T+3.
REQ-016 Peak throughput SHALL be one access per 3 cycles, so a pending request from the other port is granted in the same cycle the first port is acked.
REQ-017 A requester SHALL hold req, wr, addr and wdata stable until it sees ack, and SHALL deassert or change them on the next edge.
REQ-018 Request changes while the block is not in IDLE SHALL have no effect.
REQ-019 rdata SHALL hold its value until the next read completion for that port.

Reset
REQ-020 Asserting Reset SHALL immediately force the following values: state=IDLE, mem_cs=1, mem_wr=0, mem_address=0, mem_data=0, a_ack=b_ack=0, a_rdata=b_rdata=0, busy=0, last-grant=B (so A wins the first tie).
REQ-021 Asserting Reset in ACCESS or CAPTURE SHALL abort the access with no ack, and memory content at the aborted write address is then unspecified.
REQ-022 After Reset is released, the first arbitration SHALL occur on the first rising edge at which the FSM is in IDLE.

Structure
REQ-023 Package mem_arb_pkg SHALL hold the state encoding (IDLE, ACCESS, CAPTURE), the port-id constants (PORT_A=0, PORT_B=1) and the default ADDR_W and DATA_W.
REQ-024 The round-robin decision SHALL be implemented in sub-module rr_arbiter2 (two eligibility inputs, last-grant input, grant output, combinational); the FSM and all registers SHALL live in memory_arbiter.

Verification
REQ-025 The bench SHALL include the Memory model connected to the mem_* ports and SHALL cover the following directed scenarios:
- A writes 0x4C to 0x03, then A reads 0x03 -> a_ack three cycles after each request; a_rdata=0x4C; b_ack never pulses.
- A (write 0xB3 to 0x04) and B (read 0x04) raised in the same cycle after reset -> A is served first, B is acked three cycles later; b_rdata=0xB3.
- A and B both hold read requests continuously -> grants alternate A, B, A, B; mem_cs is low in exactly one of every three cycles.
- B writes 0x55 to 0x10 and then drops req -> b_rdata keeps its previous value; on the ack cycle the arbiter stays in IDLE with no re-grant.
- Reset asserted during ACCESS of an A read -> mem_cs=1, busy=0 and both acks 0 within the same cycle; a_rdata=0; a new request is served normally after release.
- No requests for 20 cycles -> busy=0, mem_cs=1 throughout, and no ack pulses.
